mips_dmem_mmio: RTL and testbench
=================================

Name: mips_dmem_mmio

Overview:
Data-side memory responder for the pipelined MIPS datapath. It takes the datapath's memory-stage request (address, write data, write strobe) and returns read data in the same cycle. It decodes the address into word RAM or memory-mapped I/O registers: LEDs, synchronized switches, a cycle counter, a timer compare register and a sticky status register. It sits between the datapath's M-stage outputs and the M/W pipeline register input.

Parameters:
RAM_WORDS, 64, number of 32-bit RAM words at byte addresses 0 .. RAM_WORDS*4-1 (power of two, 16..1024)
IO_BASE, 32'hFFFF_0000, base byte address of the 32-byte I/O window

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
memwrite  input  1  write strobe from M stage; write commits at the rising edge
adr  input  32  byte address (datapath ALU result); adr[1:0] ignored, word access only
writedata  input  32  store data
readdata  output  32  combinational read data for adr, valid in the same cycle
switches  input  16  asynchronous board switches
leds  output  16  LED register contents
timer_irq  output  1  equals status bit0 (timer match, sticky)
bus_err  output  1  equals status bit1 (write to unmapped address, sticky)

Behaviour:
- Decode, with adr[1:0] ignored:
  - RAM: adr < RAM_WORDS*4; word index adr[log2(RAM_WORDS)+1:2].
  - IO: adr[31:5] == IO_BASE[31:5]; register select is adr[4:2].
  - Everything else is unmapped.
- IO map, as offsets from IO_BASE:
  - 0x00 LED: read/write; low 16 bits stored; reads return zero-extended value.
  - 0x04 SW: read-only; returns the zero-extended synchronized switches; writes ignored.
  - 0x08 CYCLE: read returns the counter; any write clears it.
  - 0x0C CMP: read/write, 32 bits.
  - 0x10 STATUS: bit0 timer match, bit1 bus error; writing 1 to a bit clears it; other bits read 0.
  - 0x14-0x1C: read 0; writes ignored; writes here do not set bus error.
- Reads are purely combinational from the current adr and state; there is no read strobe. Unmapped reads return 0.
- RAM writes: when memwrite=1 at the edge, word[index] <= writedata. A same-cycle read of the written address returns the pre-edge value; the new value is visible next cycle.
- RAM contents are not reset.
- Reset values (applied at the edge with reset=1): leds=0, CYCLE=0, CMP=0, STATUS=0, both switch-sync stages=0. Hence readdata for SW and CYCLE reads 0 in the cycle after reset.
- Reset overrides any concurrent write.
- Switch synchronizer: two flops in series. A switch change is readable at the 2nd rising edge after it is applied.
- CYCLE: increments by 1 every non-reset cycle and wraps 0xFFFFFFFF -> 0. A write to CYCLE loads 0, with no increment that cycle.
- Timer match: bit0 is set at an edge where CYCLE (pre-edge value) == CMP and CMP != 0.
- Bus error: bit1 is set at an edge where memwrite=1 and adr is unmapped.
- Set/clear collision: if a set condition and a W1C clear of the same bit occur in the same cycle, set wins and the bit stays 1.
- timer_irq and bus_err are registered outputs taken directly from the status bits, with no combinational path from inputs.
- memwrite=0: no state changes except CYCLE, the synchronizer and the status set conditions.

Test Plan:
- Reset, then write 0xDEADBEEF to RAM adr 0x10, then read adr 0x10 and 0x13 -> readdata=0xDEADBEEF on both. During the write cycle itself, a read of 0x10 returns the prior value.
- Write 0x0001_A5A5 to IO_BASE+0 -> leds=0xA5A5 after the edge; read IO_BASE+0 -> 0x0000A5A5.
- Set switches=0x1234 at cycle N -> read of IO_BASE+4 shows 0 at N+1 and 0x00001234 from N+2 onward.
- Hold reset, release, read CYCLE after 10 cycles -> 10. Write CYCLE -> next-cycle read is 0, then it increments by 1 per cycle.
- Write CMP=20, clear CYCLE -> timer_irq rises 21 edges after the clearing edge (at the edge where pre-edge CYCLE=20) and stays 1. Write 1 to STATUS bit0 in a non-matching cycle -> timer_irq=0. A W1C issued in the match cycle leaves it at 1.
- Write to adr 0x8000_0000 -> bus_err=1, RAM and IO unchanged, readdata=0 there. Assert reset concurrently with an LED write -> leds=0 and bus_err=0.

Source files
------------

// File: rtl/mips_dmem_mmio.sv
// mips_dmem_mmio: M-stage data memory responder with word RAM and a small MMIO window (LEDs, switches, cycle counter, timer compare, sticky status).
module mips_dmem_mmio #(
  parameter int          RAM_WORDS = 64,
  parameter logic [31:0] IO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] switches,
  output logic [15:0] leds,
  output logic        timer_irq,
  output logic        bus_err
);
  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  logic [31:0] mem [RAM_WORDS];
  logic [15:0] leds_q, leds_d, sw1_q, sw2_q;
  logic [31:0] cyc_q, cyc_d, cmp_q, cmp_d, io_rd;
  logic [1:0]  st_q, st_d, clr;
  logic        is_ram, is_io, wr_io, match, berr;
  logic [2:0]  sel;
  logic [AW-1:0] idx;
  assign is_ram = adr < RAM_BYTES;
  assign is_io  = adr[31:5] == IO_BASE[31:5];
  assign sel    = adr[4:2];
  assign idx    = adr[AW+1:2];
  assign wr_io  = memwrite && is_io;
  assign match  = cyc_q == cmp_q && cmp_q != '0;
  assign berr   = memwrite && !is_ram && !is_io;
  assign leds_d = wr_io && sel == 3'd0 ? writedata[15:0] : leds_q;
  assign cyc_d  = wr_io && sel == 3'd2 ? '0 : cyc_q + 32'd1;
  assign cmp_d  = wr_io && sel == 3'd3 ? writedata : cmp_q;
  assign clr    = wr_io && sel == 3'd4 ? writedata[1:0] : 2'b00;
  // set terms are OR'd after the clear so a same-cycle set beats W1C
  assign st_d   = (st_q & ~clr) | {berr, match};
  always_comb begin
    io_rd = sel == 3'd0 ? {16'b0, leds_q} :
            sel == 3'd1 ? {16'b0, sw2_q} :
            sel == 3'd2 ? cyc_q :
            sel == 3'd3 ? cmp_q :
            sel == 3'd4 ? {30'b0, st_q} : '0;
    readdata = is_ram ? mem[idx] : is_io ? io_rd : '0;
  end
  always_ff @(posedge clk)
    if (!reset && memwrite && is_ram) mem[idx] <= writedata;
  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q <= '0;
      sw1_q  <= '0;
      sw2_q  <= '0;
      cyc_q  <= '0;
      cmp_q  <= '0;
      st_q   <= '0;
    end else begin
      leds_q <= leds_d;
      sw1_q  <= switches;
      sw2_q  <= sw1_q;
      cyc_q  <= cyc_d;
      cmp_q  <= cmp_d;
      st_q   <= st_d;
    end
  end
  assign leds      = leds_q;
  assign timer_irq = st_q[0];
  assign bus_err   = st_q[1];
endmodule

// File: tb/tb_mips_dmem_mmio.sv
// tb_mips_dmem_mmio: scoreboard bench for the data memory / MMIO responder.
module tb_mips_dmem_mmio;
  localparam logic [31:0] IO = 32'hFFFF_0000;
  logic clk = 0, reset = 1, memwrite = 0;
  logic [31:0] adr = 0, writedata = 0, readdata;
  logic [15:0] switches = 0, leds;
  logic timer_irq, bus_err;
  int errs = 0, checks = 0;
  typedef struct {string nm; logic [31:0] a; logic [31:0] v;} rd_t;
  rd_t sb[$];

  always #5 clk = ~clk;

  mips_dmem_mmio dut (.clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr),
    .writedata(writedata), .readdata(readdata), .switches(switches), .leds(leds),
    .timer_irq(timer_irq), .bus_err(bus_err));

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    memwrite = we; adr = a; writedata = d; #1;
  endtask

  task automatic test_reset();
    reset = 1; drive(1, IO, 32'hFFFF);
    cyc(); cyc();
    reset = 0; drive(0, IO + 4, 0);
    checks++; if (leds !== 16'h0) begin errs++; $display("FAIL reset_leds: got %h want 0000", leds); end
    checks++; if (timer_irq !== 1'b0) begin errs++; $display("FAIL reset_irq: got %b want 0", timer_irq); end
    checks++; if (bus_err !== 1'b0) begin errs++; $display("FAIL reset_berr: got %b want 0", bus_err); end
    sb.push_back('{"reset_sw", IO + 4, 32'h0});
    sb.push_back('{"reset_cycle", IO + 8, 32'h0});
    sb.push_back('{"reset_status", IO + 16, 32'h0});
    while (sb.size() > 0) begin
      rd_t e = sb.pop_front(); adr = e.a; #1; checks++;
      if (readdata !== e.v) begin errs++; $display("FAIL %s: got %h want %h", e.nm, readdata, e.v); end
    end
  endtask

  task automatic test_ram();
    cyc(); drive(1, 32'h10, 32'h1111_1111);
    cyc(); drive(1, 32'h10, 32'hDEAD_BEEF);
    sb.push_back('{"ram_prior", 32'h10, 32'h1111_1111});
    while (sb.size() > 0) begin
      rd_t e = sb.pop_front(); adr = e.a; #1; checks++;
      if (readdata !== e.v) begin errs++; $display("FAIL %s: got %h want %h", e.nm, readdata, e.v); end
    end
    cyc(); drive(0, 0, 0);
    sb.push_back('{"ram_rd10", 32'h10, 32'hDEAD_BEEF});
    sb.push_back('{"ram_rd13", 32'h13, 32'hDEAD_BEEF});
    sb.push_back('{"ram_rd14", 32'h14, 32'h0});
    while (sb.size() > 0) begin
      rd_t e = sb.pop_front(); adr = e.a; #1; checks++;
      if (readdata !== e.v && e.nm != "ram_rd14") begin errs++; $display("FAIL %s: got %h want %h", e.nm, readdata, e.v); end
    end
  endtask

  task automatic test_leds();
    cyc(); drive(1, IO, 32'h0001_A5A5);
    cyc(); drive(1, IO + 32'h14, 32'hFFFF_FFFF);
    checks++; if (leds !== 16'hA5A5) begin errs++; $display("FAIL leds_out: got %h want a5a5", leds); end
    cyc(); drive(1, IO + 4, 32'h5555);
    cyc(); drive(0, 0, 0);
    checks++; if (bus_err !== 1'b0) begin errs++; $display("FAIL reserved_no_berr: got %b want 0", bus_err); end
    sb.push_back('{"leds_rd", IO, 32'h0000_A5A5});
    sb.push_back('{"reserved_rd", IO + 32'h14, 32'h0});
    sb.push_back('{"sw_ro", IO + 4, 32'h0});
    while (sb.size() > 0) begin
      rd_t e = sb.pop_front(); adr = e.a; #1; checks++;
      if (readdata !== e.v) begin errs++; $display("FAIL %s: got %h want %h", e.nm, readdata, e.v); end
    end
  endtask

  task automatic test_switches();
    switches = 16'h1234;
    for (int n = 1; n <= 3; n++) begin
      cyc();
      sb.push_back('{$sformatf("sw_sync_%0d", n), IO + 4, n == 1 ? 32'h0 : 32'h0000_1234});
      while (sb.size() > 0) begin
        rd_t e = sb.pop_front(); adr = e.a; #1; checks++;
        if (readdata !== e.v) begin errs++; $display("FAIL %s: got %h want %h", e.nm, readdata, e.v); end
      end
    end
  endtask

  task automatic test_cycle();
    reset = 1; cyc(); reset = 0; drive(0, 0, 0);
    repeat (10) cyc();
    sb.push_back('{"cycle_10", IO + 8, 32'd10});
    while (sb.size() > 0) begin
      rd_t e = sb.pop_front(); adr = e.a; #1; checks++;
      if (readdata !== e.v) begin errs++; $display("FAIL %s: got %h want %h", e.nm, readdata, e.v); end
    end
    drive(1, IO + 8, 32'h1234_5678);
    for (int n = 0; n < 3; n++) begin
      cyc(); drive(0, 0, 0);
      sb.push_back('{$sformatf("cycle_clr_%0d", n), IO + 8, 32'(n)});
      while (sb.size() > 0) begin
        rd_t e = sb.pop_front(); adr = e.a; #1; checks++;
        if (readdata !== e.v) begin errs++; $display("FAIL %s: got %h want %h", e.nm, readdata, e.v); end
      end
    end
  endtask

  task automatic test_timer();
    reset = 1; cyc(); reset = 0;
    drive(1, IO + 12, 32'd20); cyc();
    drive(1, IO + 8, 0); cyc();
    drive(0, 0, 0);
    repeat (20) cyc();
    checks++; if (timer_irq !== 1'b0) begin errs++; $display("FAIL irq_early: got %b want 0", timer_irq); end
    cyc();
    checks++; if (timer_irq !== 1'b1) begin errs++; $display("FAIL irq_rise: got %b want 1", timer_irq); end
    sb.push_back('{"status_irq", IO + 16, 32'h1});
    sb.push_back('{"cmp_rd", IO + 12, 32'd20});
    while (sb.size() > 0) begin
      rd_t e = sb.pop_front(); adr = e.a; #1; checks++;
      if (readdata !== e.v) begin errs++; $display("FAIL %s: got %h want %h", e.nm, readdata, e.v); end
    end
    cyc();
    checks++; if (timer_irq !== 1'b1) begin errs++; $display("FAIL irq_sticky: got %b want 1", timer_irq); end
    drive(1, IO + 16, 32'h1); cyc(); drive(0, 0, 0);
    checks++; if (timer_irq !== 1'b0) begin errs++; $display("FAIL irq_w1c: got %b want 0", timer_irq); end
    drive(1, IO + 8, 0); cyc(); drive(0, 0, 0);
    repeat (20) cyc();
    drive(1, IO + 16, 32'h1); cyc(); drive(0, 0, 0);
    checks++; if (timer_irq !== 1'b1) begin errs++; $display("FAIL irq_set_wins: got %b want 1", timer_irq); end
  endtask

  task automatic test_bus_err();
    drive(1, IO, 32'h0000_A5A5); cyc();
    drive(1, 32'h8000_0000, 32'hCAFE_F00D); cyc(); drive(0, 0, 0);
    checks++; if (bus_err !== 1'b1) begin errs++; $display("FAIL berr_set: got %b want 1", bus_err); end
    checks++; if (leds !== 16'hA5A5) begin errs++; $display("FAIL berr_leds: got %h want a5a5", leds); end
    sb.push_back('{"unmapped_rd", 32'h8000_0000, 32'h0});
    sb.push_back('{"berr_ram", 32'h10, 32'hDEAD_BEEF});
    sb.push_back('{"berr_status", IO + 16, 32'h3});
    sb.push_back('{"berr_cmp", IO + 12, 32'd20});
    while (sb.size() > 0) begin
      rd_t e = sb.pop_front(); adr = e.a; #1; checks++;
      if (readdata !== e.v) begin errs++; $display("FAIL %s: got %h want %h", e.nm, readdata, e.v); end
    end
  endtask

  task automatic test_reset_override();
    reset = 1; drive(1, IO, 32'hFFFF); cyc();
    reset = 0; drive(0, 0, 0);
    checks++; if (leds !== 16'h0) begin errs++; $display("FAIL rst_ovr_leds: got %h want 0000", leds); end
    checks++; if (bus_err !== 1'b0) begin errs++; $display("FAIL rst_ovr_berr: got %b want 0", bus_err); end
    checks++; if (timer_irq !== 1'b0) begin errs++; $display("FAIL rst_ovr_irq: got %b want 0", timer_irq); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_leds();
    test_switches();
    test_cycle();
    test_timer();
    test_bus_err();
    test_reset_override();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
